// File: rtl/l1_l2_arbiter_pkg.sv
// Shared types and default widths for the L1/L2 request arbiter.
package arb_types;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating event counter with a synchronous clear; clear beats increment.
module arb_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // Count up on inc, stick at all-ones, clear or reset to zero
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/l1_l2_arbiter.sv
// Shares the single L2 port between the L1 I-cache and L1 D-cache.
// One owner at a time, grant held until mem_resp, round-robin on ties.
module l1_l2_arbiter
    import arb_types::*;
#(
    parameter int unsigned LINE_W = arb_types::LINE_W,
    parameter int unsigned ADDR_W = arb_types::ADDR_W,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,

    input  logic              conflict_clear,
    output logic [CNT_W-1:0]  conflict_count
);

    arb_state_t state_q, state_d;
    arb_owner_t last_owner_q, last_owner_d;

    logic i_req;
    logic d_req;
    logic conflict_inc;

    assign i_req        = i_read;
    assign d_req        = d_read | d_write;
    assign conflict_inc = (state_q == ARB_IDLE) && i_req && d_req;

    // Next-state: pick an owner from IDLE, release it on mem_resp
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            ARB_IDLE: begin
                if (i_req && d_req) begin
                    state_d = (last_owner_q == OWN_I) ? ARB_SERVE_D : ARB_SERVE_I;
                end else if (d_req) begin
                    state_d = ARB_SERVE_D;
                end else if (i_req) begin
                    state_d = ARB_SERVE_I;
                end
            end
            ARB_SERVE_I: begin
                if (mem_resp) begin
                    state_d      = ARB_IDLE;
                    last_owner_d = OWN_I;
                end
            end
            ARB_SERVE_D: begin
                if (mem_resp) begin
                    state_d      = ARB_IDLE;
                    last_owner_d = OWN_D;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and round-robin history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= OWN_I;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Steer the owner's live request onto L2 and L2's response back to the owner
    always_comb begin
        mem_address = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_wdata   = '0;
        i_rdata     = '0;
        i_resp      = 1'b0;
        d_rdata     = '0;
        d_resp      = 1'b0;
        case (state_q)
            ARB_SERVE_I: begin
                mem_address = i_address;
                mem_read    = i_read;
                i_rdata     = mem_rdata;
                i_resp      = mem_resp;
            end
            ARB_SERVE_D: begin
                mem_address = d_address;
                mem_write   = d_write;
                mem_read    = d_read & ~d_write;
                mem_wdata   = d_wdata;
                d_rdata     = mem_rdata;
                d_resp      = mem_resp;
            end
            default: ;
        endcase
    end

    arb_sat_counter #(
        .WIDTH (CNT_W)
    ) u_conflict_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (conflict_inc),
        .clr   (conflict_clear),
        .count (conflict_count)
    );

    // An L1 must keep its request up until its response pulse
    a_i_hold: assert property (@(posedge clk) disable iff (rst)
        (state_q == ARB_SERVE_I) |-> i_req);
    a_d_hold: assert property (@(posedge clk) disable iff (rst)
        (state_q == ARB_SERVE_D) |-> d_req);

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed bench for l1_l2_arbiter with an expected-grant scoreboard.
// A second instance with a 2-bit counter shares all inputs to exercise saturation.
module tb_l1_l2_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] i_address = '0;
    logic          i_read = 1'b0;
    logic [AW-1:0] d_address = '0;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] mem_rdata = '0;
    logic          mem_resp = 1'b0;
    logic          conflict_clear = 1'b0;

    logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
    logic          i_resp, d_resp, mem_read, mem_write;
    logic [AW-1:0] mem_address;
    logic [31:0]   conflict_count;

    logic [LW-1:0] s_i_rdata, s_d_rdata, s_mem_wdata;
    logic          s_i_resp, s_d_resp, s_mem_read, s_mem_write;
    logic [AW-1:0] s_mem_address;
    logic [1:0]    s_conflict_count;

    always #5 clk = ~clk;

    l1_l2_arbiter #(.LINE_W(LW), .ADDR_W(AW), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .conflict_clear(conflict_clear), .conflict_count(conflict_count)
    );

    l1_l2_arbiter #(.LINE_W(LW), .ADDR_W(AW), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read), .i_rdata(s_i_rdata), .i_resp(s_i_resp),
        .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(s_d_rdata), .d_resp(s_d_resp),
        .mem_address(s_mem_address), .mem_read(s_mem_read), .mem_write(s_mem_write),
        .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .conflict_clear(conflict_clear), .conflict_count(s_conflict_count)
    );

    typedef struct {
        logic          is_d;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } txn_t;

    txn_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic is_d, input logic wr,
                                input logic [AW-1:0] a, input logic [LW-1:0] wd);
        txn_t t;
        t.is_d  = is_d;
        t.wr    = wr;
        t.addr  = a;
        t.wdata = wd;
        return t;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_rd"},   mem_read, 1'b0);
        chk({tag, "_wr"},   mem_write, 1'b0);
        chk({tag, "_addr"}, mem_address, '0);
        chk({tag, "_wd"},   mem_wdata, '0);
        chk({tag, "_resp"}, {i_resp, d_resp}, 2'b00);
    endtask

    task automatic chk_cnt(input string tag, input int main_exp);
        chk({tag, "_cnt"},     conflict_count, main_exp);
        chk({tag, "_cnt_sat"}, s_conflict_count, (main_exp > 3) ? 3 : main_exp);
    endtask

    // Wait for the next grant, check it against the scoreboard, respond after lat cycles
    task automatic service(input int lat, input logic [LW-1:0] rd,
                           input logic drop_i, input logic drop_d);
        txn_t          e;
        int            n;
        logic [LW-1:0] zero;
        zero = '0;
        e = sbq.pop_front();
        n = 0;
        while (!(mem_read || mem_write) && n < 20) begin
            @(negedge clk); #2;
            n++;
        end
        chk("grant_latency", n, 1);
        chk("mem_address", mem_address, e.addr);
        chk("mem_write", mem_write, e.wr);
        chk("mem_read", mem_read, !e.wr);
        chk("mem_wdata", mem_wdata, e.is_d ? e.wdata : zero);
        chk("sat_mem_address", s_mem_address, e.addr);
        chk("sat_mem_rw", {s_mem_read, s_mem_write}, {!e.wr, e.wr});
        chk("sat_mem_wdata", s_mem_wdata, e.is_d ? e.wdata : zero);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk); #2;
            chk("early_resp", {i_resp, d_resp}, 2'b00);
            chk("req_held", mem_read | mem_write, 1'b1);
        end
        @(negedge clk);
        mem_rdata = rd;
        mem_resp  = 1'b1;
        #2;
        chk("i_resp", i_resp, !e.is_d);
        chk("d_resp", d_resp, e.is_d);
        chk("i_rdata", i_rdata, e.is_d ? zero : rd);
        chk("d_rdata", d_rdata, e.is_d ? rd : zero);
        chk("sat_resp", {s_i_resp, s_d_resp}, {!e.is_d, e.is_d});
        chk("sat_rdata", s_i_rdata | s_d_rdata, rd);
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = '0;
        if (drop_i) i_read = 1'b0;
        if (drop_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
        #2;
        chk("bubble", {mem_read, mem_write, i_resp, d_resp}, 4'b0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        chk_idle("reset");
        chk_cnt("reset", 0);

        // Single I read, L2 latency 3
        @(negedge clk);
        i_address = 32'h0000_0040;
        i_read    = 1'b1;
        sbq.push_back(mk(1'b0, 1'b0, 32'h0000_0040, '0));
        #2;
        chk("i_arb_bubble", mem_read, 1'b0);
        service(3, {8{32'hDEADBEEF}}, 1'b1, 1'b0);

        // D write-back
        @(negedge clk);
        d_address = 32'h0000_1000;
        d_wdata   = {8{32'h12345678}};
        d_write   = 1'b1;
        sbq.push_back(mk(1'b1, 1'b1, 32'h0000_1000, {8{32'h12345678}}));
        #2;
        chk("d_arb_bubble", mem_write, 1'b0);
        service(2, {8{32'hCAFEF00D}}, 1'b0, 1'b1);
        chk_idle("after_wb");

        // Illegal read+write from D: the write wins
        @(negedge clk);
        d_address = 32'h0000_1040;
        d_wdata   = {8{32'hA5A55A5A}};
        d_read    = 1'b1;
        d_write   = 1'b1;
        sbq.push_back(mk(1'b1, 1'b1, 32'h0000_1040, {8{32'hA5A55A5A}}));
        #2;
        service(1, {8{32'h0BADF00D}}, 1'b0, 1'b1);

        // Stray mem_resp in IDLE is ignored
        @(negedge clk);
        mem_resp  = 1'b1;
        mem_rdata = {8{32'hFFFF0000}};
        #2;
        chk("idle_resp", {i_resp, d_resp}, 2'b00);
        chk("idle_rdata", i_rdata | d_rdata, '0);
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = '0;
        #2;
        chk_idle("idle_after_stray");
        chk_cnt("no_conflict_yet", 0);

        // Simultaneous first requests after reset: D first, then I
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        i_address = 32'h0000_0080;
        d_address = 32'h0000_2000;
        i_read    = 1'b1;
        d_read    = 1'b1;
        sbq.push_back(mk(1'b1, 1'b0, 32'h0000_2000, d_wdata));
        sbq.push_back(mk(1'b0, 1'b0, 32'h0000_0080, '0));
        #2;
        service(2, {8{32'h11111111}}, 1'b0, 1'b1);
        service(2, {8{32'h22222222}}, 1'b1, 1'b0);
        chk_cnt("first_tie", 1);

        // Fairness: both keep re-requesting for 6 transactions
        @(negedge clk);
        conflict_clear = 1'b1;
        @(negedge clk);
        conflict_clear = 1'b0;
        #2;
        chk_cnt("cleared", 0);
        @(negedge clk);
        i_address = 32'h0000_00C0;
        d_address = 32'h0000_3000;
        d_wdata   = {8{32'h5A5A0F0F}};
        i_read    = 1'b1;
        d_write   = 1'b1;
        for (int t = 0; t < 3; t++) begin
            sbq.push_back(mk(1'b1, 1'b1, 32'h0000_3000, {8{32'h5A5A0F0F}}));
            sbq.push_back(mk(1'b0, 1'b0, 32'h0000_00C0, '0));
        end
        #2;
        for (int t = 0; t < 6; t++) begin
            service(1 + (t % 3), {8{32'h3C3C0000 + 32'(t)}}, t == 5, t == 5);
            chk_cnt("fair", t + 1);
        end

        // Clear together with a conflict: clear wins
        @(negedge clk);
        i_address      = 32'h0000_0100;
        d_address      = 32'h0000_4000;
        i_read         = 1'b1;
        d_read         = 1'b1;
        conflict_clear = 1'b1;
        sbq.push_back(mk(1'b1, 1'b0, 32'h0000_4000, d_wdata));
        sbq.push_back(mk(1'b0, 1'b0, 32'h0000_0100, '0));
        #2;
        fork
            begin
                @(negedge clk);
                conflict_clear = 1'b0;
            end
        join_none
        service(1, {8{32'h44444444}}, 1'b0, 1'b1);
        chk_cnt("clear_wins", 0);
        service(1, {8{32'h55555555}}, 1'b1, 1'b0);
        chk_cnt("clear_hold", 0);

        // Reset while serving D with no mem_resp
        @(negedge clk);
        d_address = 32'h0000_6000;
        d_write   = 1'b1;
        #2;
        @(negedge clk); #2;
        chk("pre_rst_wr", mem_write, 1'b1);
        chk("pre_rst_addr", mem_address, 32'h0000_6000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        d_write = 1'b0;
        #2;
        chk_idle("post_rst");
        @(negedge clk); #2;
        chk_idle("post_rst2");

        // First tie after the mid-flight reset goes to D
        @(negedge clk);
        i_address = 32'h0000_0140;
        d_address = 32'h0000_5000;
        d_wdata   = {8{32'h77778888}};
        i_read    = 1'b1;
        d_write   = 1'b1;
        sbq.push_back(mk(1'b1, 1'b1, 32'h0000_5000, {8{32'h77778888}}));
        sbq.push_back(mk(1'b0, 1'b0, 32'h0000_0140, '0));
        #2;
        service(2, {8{32'h66666666}}, 1'b0, 1'b1);
        service(1, {8{32'h99999999}}, 1'b1, 1'b0);
        chk_cnt("tie_after_rst", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l1_l2_arbiter.md
Name: l1_l2_arbiter

Overview:
- Shares the single L2 cache request port between the L1 instruction cache (read-only) and the L1 data cache (read/write). All traffic is 256-bit lines.
- Sits between the two L1 caches and the L2 cache's `mem_*` port.
- Grants one requester at a time and holds the grant until L2 responds. Uses round-robin when both requesters contend.
- Provides a saturating contention counter with a clear input, in the same style as the L2 hit/miss counters.

Parameters:
- `LINE_W`, 256, cache line width in bits.
- `ADDR_W`, 32, address width.
- `CNT_W`, 32, contention counter width.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_address`  in  ADDR_W  I-cache line address.
- `i_read`  in  1  I-cache read request.
- `i_rdata`  out  LINE_W  line returned to the I-cache.
- `i_resp`  out  1  I-cache response, one-cycle pulse.
- `d_address`  in  ADDR_W  D-cache line address.
- `d_read`  in  1  D-cache read request.
- `d_write`  in  1  D-cache write-back request.
- `d_wdata`  in  LINE_W  D-cache write-back line.
- `d_rdata`  out  LINE_W  line returned to the D-cache.
- `d_resp`  out  1  D-cache response, one-cycle pulse.
- `mem_address`  out  ADDR_W  L2 address.
- `mem_read`  out  1  L2 read.
- `mem_write`  out  1  L2 write.
- `mem_wdata`  out  LINE_W  L2 write data.
- `mem_rdata`  in  LINE_W  L2 read data.
- `mem_resp`  in  1  L2 response.
- `conflict_clear`  in  1  clears `conflict_count`.
- `conflict_count`  out  CNT_W  number of IDLE cycles in which both requesters were pending.

Behaviour:
- States: ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D. Reset sets state = ARB_IDLE, `last_owner` = I (so D wins the first tie), `conflict_count` = 0.
- Requests:
  - `i_req` = `i_read`.
  - `d_req` = `d_read` | `d_write`.
- L1 protocol: a requester holds its address, data and request level stable until its resp pulse. Dropping a request mid-service is a protocol violation; flag it with a simulation assertion, no RTL recovery.
- ARB_IDLE:
  - `mem_read`, `mem_write`, `i_resp`, `d_resp` = 0.
  - `mem_address` = 0 and `mem_wdata` = 0.
  - Only `d_req` → ARB_SERVE_D.
  - Only `i_req` → ARB_SERVE_I.
  - Both → serve the requester that is not `last_owner`.
  - Neither → stay in ARB_IDLE.
- ARB_SERVE_x:
  - Drive `mem_*` combinationally from owner x's live inputs.
  - For I: `mem_write` = 0, `mem_wdata` = 0.
  - For D: if `d_read` and `d_write` are both 1 (illegal), the write wins: `mem_write` = 1, `mem_read` = 0.
  - On `mem_resp` = 1, in the same cycle: `x_resp` = 1, and `x_rdata` = `mem_rdata`. Next state is ARB_IDLE and `last_owner` ← x.
  - Without `mem_resp`, remain in ARB_SERVE_x.
- Latency:
  - One-cycle arbitration bubble: a request seen in IDLE at cycle n reaches L2 at cycle n+1.
  - Total L1 latency = L2 latency + 1.
  - Back-to-back requests from the same or the other requester also incur the IDLE cycle.
- rdata outputs:
  - `i_rdata` = `mem_rdata` when owner = I, else 0.
  - `d_rdata` = `mem_rdata` when owner = D, else 0.
  - The non-owner never sees resp.
- `mem_resp` while in IDLE is ignored; no resp is forwarded.
- `conflict_count`:
  - Increments by 1 in any ARB_IDLE cycle with `i_req` & `d_req`.
  - Saturates at all-ones.
  - `conflict_clear` has priority over increment: the counter becomes 0 that cycle.
- Reset mid-operation:
  - State returns to ARB_IDLE and all `mem_*` requests deassert the next cycle.
  - The in-flight L2 transaction is abandoned; L1 and L2 are reset by the same `rst`.

Decomposition:
- Package `arb_types`:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D} arb_state_t`.
  - `typedef enum logic {OWN_I, OWN_D} arb_owner_t`.
  - Constants `LINE_W` and `ADDR_W`.
- Sub-module `arb_sat_counter`: parameterised by width, inputs `inc` and `clr` (clr wins), saturating. It is reusable for the L2 hit/miss counters.
- FSM, steering muxes and `last_owner` live in `l1_l2_arbiter`.

Test Plan:
- Single I read:
  - Stimulus: after reset, `i_read` = 1, `i_address` = 0x0000_0040; L2 returns `mem_resp` after 3 cycles with `mem_rdata` = {8{32'hDEADBEEF}}.
  - Required: `mem_read` = 1 and `mem_address` = 0x40 from cycle 1; `i_resp` pulses for exactly one cycle with `i_rdata` matching; `d_resp` stays 0.
- D write-back:
  - Stimulus: `d_write` = 1, `d_address` = 0x0000_1000, `d_wdata` = {8{32'h12345678}}.
  - Required: `mem_write` = 1, `mem_wdata` matches, `mem_read` = 0; `d_resp` pulses on `mem_resp`; state returns to IDLE.
- Simultaneous first requests:
  - Stimulus: `i_read` and `d_read` both asserted in the same cycle after reset.
  - Required: D is served first, then I after one IDLE bubble; `conflict_count` = 1.
- Fairness:
  - Stimulus: both requesters continuously re-request for 6 transactions.
  - Required: grant order is D, I, D, I, D, I; `conflict_count` = 6.
- Counter saturation:
  - Stimulus: force the counter to 0xFFFF_FFFE, then apply 3 conflict cycles, then a cycle with `conflict_clear` and a conflict together.
  - Required: count reads 0xFFFF_FFFF and holds there; after the clear cycle it is 0.
- Reset mid-transaction:
  - Stimulus: assert `rst` for 1 cycle while in ARB_SERVE_D with no `mem_resp`.
  - Required: the next cycle has `mem_read` = `mem_write` = 0, state ARB_IDLE, no resp pulse; the next tie is granted to D.
